arbiter_burst_scheduler: RTL and testbench
==========================================

Name: arbiter_burst_scheduler

Overview:
- Burst-granularity round-robin scheduler that shares one downstream port among NUM_REQ requesters, for example engine-to-memory-channel links.
- Unlike the per-cycle tree arbiters, it locks a grant for a whole burst of handshaken beats, then rotates priority.
- It drives the select of an external beat mux and sits between requester engines and the shared port.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..32.
- REQ_SEL_W, clog2(NUM_REQ), width of grant_select.
- BURST_W, 8, width of each burst-length field.

Ports:
- ap_clk  in  1  clock.
- areset  in  1  asynchronous reset, active-high.
- enable  in  1  when low, no new grant is issued; a burst in flight still completes.
- req_in  in  NUM_REQ  per-requester request level.
- req_burst_len  in  NUM_REQ*BURST_W  beats per requester; field i is [(i+1)*BURST_W-1 -: BURST_W]; sampled at grant.
- beat_valid  in  1  beat valid from the granted requester (post-mux).
- beat_ready  in  1  downstream accepts the beat.
- grant_out  out  NUM_REQ  one-hot grant; all zero when grant_valid is low.
- grant_select  out  REQ_SEL_W  binary index of the grant.
- grant_valid  out  1  a grant is active.
- burst_done  out  1  one-cycle pulse after the last beat.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Single clock ap_clk; reset areset is asynchronous, active-high.
- Reset values: all outputs 0, state IDLE, rr_ptr 0, beats_left 0. Assertion mid-burst aborts immediately; there is no pending state after release.
- FSM states are IDLE and GRANT. All outputs are registered.
- IDLE:
  - If enable and |req_in, pick the first set req_in bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Next cycle: state GRANT, grant_out/grant_select latch the winner, grant_valid=1, busy=1.
  - beats_left loads the winner's length; length 0 is treated as 1.
  - Latency from req_in rising in IDLE to grant_valid is 1 cycle.
- GRANT:
  - A beat counts only when beat_valid && beat_ready; each counted beat decrements beats_left.
  - Counted beat with beats_left==1: next cycle state IDLE, grant_out=0, grant_valid=0, busy=0, burst_done=1 for exactly that cycle, rr_ptr=(winner+1) mod NUM_REQ.
  - req_in, req_burst_len and enable are ignored while in GRANT; the grant holds even if the requester drops req.
- Inter-burst bubble: grant_valid is low for exactly 1 cycle between consecutive bursts. The next winner is evaluated in that IDLE cycle.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0.
- Handshake signals outside GRANT have no effect.
- beats_left is BURST_W+1 bits wide, so no overflow occurs at length 2^BURST_W-1.

Optional Feature:
- Macro: ARBITER_BURST_SCHEDULER_PERF_EN.
- Defined: adds output perf_beat_count, NUM_REQ*32 bits. Field i counts handshaken beats while requester i is granted. Each field saturates at 32'hFFFF_FFFF and is cleared by areset.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- GLAY_ARBITER_PKG holds:
  - typedef enum arb_sched_state_t {IDLE, GRANT};
  - default BURST_W constant;
  - reuse of clog2 from GLAY_FUNCTIONS_PKG.
- Sub-module arbiter_rr_pick: combinational masked priority picker.
  - Inputs req and ptr; outputs one-hot, index and any.
  - Implemented as a double-width mask-and-find-first.

Test Plan (NUM_REQ=4, BURST_W=8):
- Reset, then req_in=4'b0100 with len2=3 and ready held high -> grant_valid at +1 cycle with grant_select=2. Three counted beats, then burst_done pulses once, grant_valid falls, rr_ptr=3.
- req_in=4'b1111 held, all lengths=1, ready high -> grant_select sequence 0,1,2,3,0 with one idle cycle between each grant.
- Granted requester 1 with len=4; beat_ready toggles 1,0,0,1,1,0,1 -> burst_done only after the 4th counted beat. Dropping req_in[1] mid-burst does not end the grant.
- len=0 for requester 3 -> exactly 1 beat counted. len=255 -> 255 beats with no wrap.
- enable=0 with req_in=4'b0011 -> no grant. Drop enable during a burst -> the burst completes and no further grant follows.
- areset pulse mid-burst (beats_left=5) -> all outputs 0 asynchronously. After release, req_in=4'b0001 is granted at rr_ptr 0.
- With ARBITER_BURST_SCHEDULER_PERF_EN: after the above sequences, perf_beat_count[i] matches the bench's reference count.

Source files
------------

// File: rtl/arbiter_burst_scheduler_pkg.sv
// Shared types and constants for the burst-granularity round-robin scheduler.
package arbiter_burst_scheduler_pkg;

  localparam int unsigned BURST_W_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_sched_state_t;

  // Ceiling log2 for parameter elaboration, minimum result 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arbiter_burst_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module arbiter_burst_scheduler_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [SEL_W-1:0]   idx_o,
  output logic               any_o
);

  localparam int unsigned DW = 2 * NUM_REQ;

  logic [DW-1:0] dbl;
  logic [DW-1:0] masked;
  logic          found;

  // Upper copy of req supplies the wrapped-around candidates below ptr.
  assign dbl    = {req_i, req_i};
  assign masked = dbl & ~((DW'(1) << ptr_i) - DW'(1));

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < int'(DW); i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        idx_o = SEL_W'(i);
      end
    end
  end

  assign any_o    = |req_i;
  assign onehot_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/arbiter_burst_scheduler.sv
// Locks a round-robin grant for a whole burst of handshaken beats, then rotates.
// ARBITER_BURST_SCHEDULER_PERF_EN adds per-requester saturating beat counters.
module arbiter_burst_scheduler
  import arbiter_burst_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned REQ_SEL_W = clog2(NUM_REQ),
  parameter int unsigned BURST_W   = BURST_W_DEFAULT
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_in,
  input  logic [NUM_REQ*BURST_W-1:0] req_burst_len,
  input  logic                       beat_valid,
  input  logic                       beat_ready,
  output logic [NUM_REQ-1:0]         grant_out,
  output logic [REQ_SEL_W-1:0]       grant_select,
  output logic                       grant_valid,
  output logic                       burst_done,
`ifdef ARBITER_BURST_SCHEDULER_PERF_EN
  output logic [NUM_REQ*32-1:0]      perf_beat_count,
`endif
  output logic                       busy
);

  localparam int unsigned BL_W = BURST_W + 1;

  arb_sched_state_t     state_q, state_d;
  logic [REQ_SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BL_W-1:0]      beats_left_q, beats_left_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [REQ_SEL_W-1:0] sel_q, sel_d;
  logic                 gvalid_q, gvalid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [REQ_SEL_W-1:0] pick_idx;
  logic                 pick_any;
  logic [BURST_W-1:0]   pick_len;
  logic                 beat_fire_c;

  arbiter_burst_scheduler_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (REQ_SEL_W)
  ) u_pick (
    .req_i    (req_in),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    pick_len = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_idx == REQ_SEL_W'(i)) pick_len = req_burst_len[i*BURST_W +: BURST_W];
    end
  end

  assign beat_fire_c = (state_q == GRANT) && beat_valid && beat_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    grant_d      = grant_q;
    sel_d        = sel_q;
    gvalid_d     = gvalid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && pick_any) begin
          state_d      = GRANT;
          grant_d      = pick_onehot;
          sel_d        = pick_idx;
          gvalid_d     = 1'b1;
          busy_d       = 1'b1;
          beats_left_d = (pick_len == '0) ? BL_W'(1) : {1'b0, pick_len};
        end
      end
      GRANT: begin
        if (beat_fire_c) begin
          if (beats_left_q == BL_W'(1)) begin
            state_d      = IDLE;
            grant_d      = '0;
            gvalid_d     = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            beats_left_d = '0;
            rr_ptr_d     = sel_q + REQ_SEL_W'(1);
          end else begin
            beats_left_d = beats_left_q - BL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARBITER_BURST_SCHEDULER_PERF_EN
  logic [31:0] perf_q [NUM_REQ];
`endif

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      beats_left_q <= '0;
      grant_q      <= '0;
      sel_q        <= '0;
      gvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ARBITER_BURST_SCHEDULER_PERF_EN
      for (int i = 0; i < int'(NUM_REQ); i++) perf_q[i] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      gvalid_q     <= gvalid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
`ifdef ARBITER_BURST_SCHEDULER_PERF_EN
      if (beat_fire_c && (perf_q[sel_q] != 32'hFFFF_FFFF)) perf_q[sel_q] <= perf_q[sel_q] + 32'd1;
`endif
    end
  end

`ifdef ARBITER_BURST_SCHEDULER_PERF_EN
  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_perf
    assign perf_beat_count[g*32 +: 32] = perf_q[g];
  end
`endif

  assign grant_out    = grant_q;
  assign grant_select = sel_q;
  assign grant_valid  = gvalid_q;
  assign burst_done   = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_arbiter_burst_scheduler.sv
// Scoreboard bench for arbiter_burst_scheduler (NUM_REQ=4, BURST_W=8).
module tb_arbiter_burst_scheduler;

  logic        ap_clk;
  logic        areset;
  logic        enable;
  logic [3:0]  req_in;
  logic [31:0] req_burst_len;
  logic        beat_valid;
  logic        beat_ready;
  logic [3:0]  grant_out;
  logic [1:0]  grant_select;
  logic        grant_valid;
  logic        burst_done;
  logic        busy;
`ifdef ARBITER_BURST_SCHEDULER_PERF_EN
  logic [127:0] perf_beat_count;
`endif

  arbiter_burst_scheduler #(.NUM_REQ(4), .REQ_SEL_W(2), .BURST_W(8)) dut (
    .ap_clk        (ap_clk),
    .areset        (areset),
    .enable        (enable),
    .req_in        (req_in),
    .req_burst_len (req_burst_len),
    .beat_valid    (beat_valid),
    .beat_ready    (beat_ready),
    .grant_out     (grant_out),
    .grant_select  (grant_select),
    .grant_valid   (grant_valid),
    .burst_done    (burst_done),
`ifdef ARBITER_BURST_SCHEDULER_PERF_EN
    .perf_beat_count (perf_beat_count),
`endif
    .busy          (busy)
  );

  typedef struct {
    int idx;
    int beats;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ref_perf[4];
  bit   prev_gv = 1'b0;
  int   beat_cnt = 0;
  bit   seen_reset = 1'b0;

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_len(input int idx, input int len);
    req_burst_len[idx*8 +: 8] = 8'(len);
  endtask

  task automatic push(input int idx, input int beats);
    exp_t e;
    e.idx = idx;
    e.beats = beats;
    sb.push_back(e);
  endtask

  task automatic check_perf();
`ifdef ARBITER_BURST_SCHEDULER_PERF_EN
    for (int i = 0; i < 4; i++) check($sformatf("perf_%0d", i), perf_beat_count[i*32 +: 32], 32'(ref_perf[i]));
`endif
  endtask

  task automatic do_reset();
    if (seen_reset) check_perf();
    seen_reset = 1'b1;
    areset = 1'b1;
    req_in = '0;
    enable = 1'b1;
    req_burst_len = '0;
    beat_valid = 1'b1;
    beat_ready = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) ref_perf[i] = 0;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!burst_done && n < bound) begin
      tick();
      n++;
    end
    if (!burst_done) check("done_timeout", 32'(burst_done), 32'd1);
  endtask

  // Monitor: grants and burst completions are checked against the scoreboard.
  always @(negedge ap_clk) begin
    if (!areset) begin
      check("busy_eq_gvalid", 32'(busy), 32'(grant_valid));
      if (!grant_valid) check("grant_out_idle", 32'(grant_out), 32'd0);
      if (grant_valid && !prev_gv) begin
        beat_cnt = 0;
        if (sb.size() == 0) check("unexpected_grant", 32'(grant_select), 32'hFFFF_FFFF);
        else begin
          check("grant_select", 32'(grant_select), 32'(sb[0].idx));
          check("grant_onehot", 32'(grant_out), 32'd1 << sb[0].idx);
        end
      end
      if (grant_valid && beat_valid && beat_ready) begin
        beat_cnt++;
        ref_perf[grant_select]++;
      end
      if (burst_done) begin
        check("done_gvalid_low", 32'(grant_valid), 32'd0);
        if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          check("burst_beats", 32'(beat_cnt), 32'(sb[0].beats));
          void'(sb.pop_front());
        end
      end
    end
    prev_gv = grant_valid;
  end

  logic seq [7];
  int   n;

  initial begin
    seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset values and single 3-beat burst on requester 2.
    do_reset();
    check("rst_grant_out", 32'(grant_out), 32'd0);
    check("rst_sel", 32'(grant_select), 32'd0);
    check("rst_gvalid", 32'(grant_valid), 32'd0);
    check("rst_done", 32'(burst_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    set_len(2, 3);
    req_in = 4'b0100;
    push(2, 3);
    tick();
    check("t1_latency", 32'(grant_valid), 32'd1);
    check("t1_sel", 32'(grant_select), 32'd2);
    req_in = '0;
    tick();
    tick();
    check("t1_hold", 32'(grant_valid), 32'd1);
    tick();
    check("t1_done", 32'(burst_done), 32'd1);
    check("t1_gv_fall", 32'(grant_valid), 32'd0);
    tick();
    check("t1_done_once", 32'(burst_done), 32'd0);
    // rr_ptr is now 3: requester 3 beats requester 0.
    set_len(3, 1);
    req_in = 4'b1001;
    push(3, 1);
    tick();
    check("t1_ptr3", 32'(grant_select), 32'd3);
    req_in = '0;
    wait_done(10, n);
    tick();

    // Fairness rotation with one-cycle bubbles.
    do_reset();
    req_in = 4'b1111;
    for (int i = 0; i < 4; i++) set_len(i, 1);
    push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(0, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("t2_gv_%0d", k), 32'(grant_valid), 32'((k % 2) == 0));
      if (k == 8) req_in = '0;
    end
    tick();
    check("t2_no_more", 32'(grant_valid), 32'd0);

    // Back-pressured 4-beat burst; req drop mid-burst is ignored.
    do_reset();
    beat_ready = 1'b0;
    set_len(1, 4);
    req_in = 4'b0010;
    push(1, 4);
    tick();
    check("t3_grant", 32'(grant_select), 32'd1);
    for (int j = 0; j < 7; j++) begin
      beat_ready = seq[j];
      if (j == 2) req_in = '0;
      tick();
      check($sformatf("t3_done_%0d", j), 32'(burst_done), 32'(j == 6));
      check($sformatf("t3_gv_%0d", j), 32'(grant_valid), 32'(j != 6));
    end
    beat_ready = 1'b1;
    tick();

    // Length 0 acts as 1; length 255 runs without wrap.
    do_reset();
    set_len(3, 0);
    req_in = 4'b1000;
    push(3, 1);
    tick();
    check("t4_gv0", 32'(grant_valid), 32'd1);
    wait_done(10, n);
    check("t4_len0_cycles", 32'(n), 32'd1);
    set_len(3, 255);
    push(3, 255);
    tick();
    check("t4_gv255", 32'(grant_valid), 32'd1);
    req_in = '0;
    wait_done(400, n);
    check("t4_len255_cycles", 32'(n), 32'd255);
    tick();

    // enable gating.
    do_reset();
    enable = 1'b0;
    set_len(0, 3);
    req_in = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_no_grant", 32'(grant_valid), 32'd0);
    end
    enable = 1'b1;
    push(0, 3);
    tick();
    check("t5_grant", 32'(grant_select), 32'd0);
    enable = 1'b0;
    wait_done(10, n);
    check("t5_len_cycles", 32'(n), 32'd3);
    for (int k = 0; k < 3; k++) tick();
    check("t5_stays_idle", 32'(busy), 32'd0);
    req_in = '0;
    enable = 1'b1;

    // Asynchronous abort mid-burst.
    do_reset();
    set_len(1, 1);
    req_in = 4'b0010;
    push(1, 1);
    tick();
    wait_done(10, n);
    set_len(2, 8);
    req_in = 4'b0100;
    push(2, 8);
    tick();
    check("t6_grant2", 32'(grant_select), 32'd2);
    req_in = '0;
    tick(); tick(); tick();
    check_perf();
    #2;
    areset = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) ref_perf[i] = 0;
    #1;
    check("t6_async_gv", 32'(grant_valid), 32'd0);
    check("t6_async_go", 32'(grant_out), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_sel", 32'(grant_select), 32'd0);
    tick();
    areset = 1'b0;
    set_len(1, 2);
    req_in = 4'b0110;
    push(1, 2);
    tick();
    check("t6_ptr0", 32'(grant_select), 32'd1);
    req_in = '0;
    wait_done(10, n);
    tick();
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    check_perf();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
